microwave_timer_ctrl: RTL

Cook-time controller for the microwave datapath. It holds and edits the remaining cook time in whole seconds, counts it down while the mode FSM is in RUN, and pauses it in STOP. It feeds `run_time` back to the mode FSM, drives the heater enable and finish beeper, and supplies minute/second values to the display driver. It sits between the debounced button/door inputs and the mode FSM, consuming the FSM's `mode` output.

---
 rtl/microwave_pkg.sv | 18 +
 rtl/microwave_tick_gen.sv | 41 ++++
 rtl/microwave_timer_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// Shared constants for the microwave controller: mode encodings and time range.
package microwave_pkg;

    localparam int unsigned TIME_W  = 14;
    localparam int unsigned MAX_SEC = 5999;

    localparam logic [2:0] MODE_IDLE   = 3'd0;
    localparam logic [2:0] MODE_SET    = 3'd1;
    localparam logic [2:0] MODE_RUN    = 3'd2;
    localparam logic [2:0] MODE_STOP   = 3'd3;
    localparam logic [2:0] MODE_FINISH = 3'd4;

    // Codes above FINISH carry no meaning and behave as IDLE.
    function automatic logic [2:0] norm_mode(input logic [2:0] m);
        return (m > MODE_FINISH) ? MODE_IDLE : m;
    endfunction

endpackage

// File: rtl/microwave_tick_gen.sv
// Sub-second counter: wraps every TICK_CYCLES cycles, flags the last cycle
// of each second (tick) and the first half of each second (half).
module microwave_tick_gen #(
    parameter int unsigned TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick_c,
    output logic half_c
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(TICK_CYCLES / 2);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_c;
    logic [CNT_W-1:0] count_nxt;

    // Clear acts in the current cycle so the new mode sees phase 0 immediately.
    always_comb begin
        count_c   = clear ? '0 : count_q;
        tick_c    = (count_c == LAST);
        half_c    = (count_c < HALF);
        count_nxt = count_c;
        if (enable) begin
            count_nxt = tick_c ? '0 : count_c + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
        end
    end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Cook-time controller: edits, counts down and displays the remaining time,
// and drives the heater enable and finish beeper from the mode FSM state.
module microwave_timer_ctrl #(
    parameter int unsigned TICK_CYCLES = 100_000_000,
    parameter int unsigned STEP_SEC    = 10,
    parameter int unsigned QUICK_SEC   = 30,
    parameter int unsigned MAX_SEC     = microwave_pkg::MAX_SEC
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [2:0]                        mode,
    input  logic                              btnU,
    input  logic                              btnD,
    input  logic                              door,
    output logic [microwave_pkg::TIME_W-1:0]  run_time,
    output logic [6:0]                        disp_min,
    output logic [5:0]                        disp_sec,
    output logic                              heater_on,
    output logic                              beep
);

    import microwave_pkg::*;

    // One spare bit so additions can be compared against the limit before clamping.
    localparam int unsigned CALC_W = TIME_W + 1;
    localparam logic [CALC_W-1:0] STEP_V  = CALC_W'(STEP_SEC);
    localparam logic [CALC_W-1:0] QUICK_V = CALC_W'(QUICK_SEC);
    localparam logic [CALC_W-1:0] MAX_V   = CALC_W'(MAX_SEC);

    logic              btn_u_d;
    logic              btn_d_d;
    logic [2:0]        mode_d;
    logic [2:0]        mode_c;
    logic              press_u_c;
    logic              press_d_c;
    logic              clear_c;
    logic              enable_c;
    logic              tick_c;
    logic              half_c;
    logic [CALC_W-1:0] rt_wide_c;
    logic [CALC_W-1:0] sum_c;
    logic [TIME_W-1:0] run_time_nxt;
    logic              heater_nxt;
    logic              beep_nxt;

    function automatic logic [TIME_W-1:0] clamp_max(input logic [CALC_W-1:0] v);
        return (v > MAX_V) ? TIME_W'(MAX_V) : TIME_W'(v);
    endfunction

    // Mode decode, button edges and sub-second counter control.
    always_comb begin
        mode_c    = norm_mode(mode);
        press_u_c = btnU & ~btn_u_d;
        press_d_c = btnD & ~btn_d_d;
        clear_c   = (mode_c == MODE_IDLE) || (mode_c == MODE_SET) ||
                    ((mode_c == MODE_FINISH) && (mode_d != MODE_FINISH));
        enable_c  = (mode_c == MODE_RUN) || (mode_c == MODE_FINISH);
    end

    microwave_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear_c),
        .enable (enable_c),
        .tick_c (tick_c),
        .half_c (half_c)
    );

    // Remaining-time update and the output decodes that depend on it.
    always_comb begin
        rt_wide_c    = CALC_W'(run_time);
        sum_c        = rt_wide_c;
        run_time_nxt = run_time;
        case (mode_c)
            MODE_SET: begin
                if (press_u_c && !press_d_c) begin
                    sum_c        = rt_wide_c + STEP_V;
                    run_time_nxt = clamp_max(sum_c);
                end else if (press_d_c && !press_u_c) begin
                    run_time_nxt = (rt_wide_c >= STEP_V) ? TIME_W'(rt_wide_c - STEP_V) : '0;
                end
            end
            MODE_RUN: begin
                sum_c        = rt_wide_c - CALC_W'(tick_c && (run_time != '0))
                             + (press_u_c ? QUICK_V : '0);
                run_time_nxt = clamp_max(sum_c);
            end
            MODE_STOP: run_time_nxt = run_time;
            default:   run_time_nxt = '0;
        endcase
        heater_nxt = (mode_c == MODE_RUN) && !door && (run_time_nxt != '0);
        beep_nxt   = (mode_c == MODE_FINISH) && half_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_u_d   <= 1'b0;
            btn_d_d   <= 1'b0;
            mode_d    <= MODE_IDLE;
            run_time  <= '0;
            disp_min  <= '0;
            disp_sec  <= '0;
            heater_on <= 1'b0;
            beep      <= 1'b0;
        end else begin
            btn_u_d   <= btnU;
            btn_d_d   <= btnD;
            mode_d    <= mode_c;
            run_time  <= run_time_nxt;
            disp_min  <= 7'(run_time / TIME_W'(60));
            disp_sec  <= 6'(run_time % TIME_W'(60));
            heater_on <= heater_nxt;
            beep      <= beep_nxt;
        end
    end

endmodule
